bsg_mesh_router_output_arb_5: RTL
=================================

# bsg_mesh_router_output_arb_5

Output stage of the 5-port dimension-order mesh router. It sits directly downstream of the DOR decoder and consumes that decoder's 25-bit request matrix. For each output direction it round-robin arbitrates among the requesting inputs and dequeues the winner (yumi). The winning flit is captured into a one-entry output register with a valid/ready handshake toward the neighbouring link.

## Interface
Port/direction index everywhere: 0=P (proc), 1=W, 2=E, 3=N, 4=S.

Parameters:
- width_p, 32, flit data width in bits.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- req_i  input  25  request matrix; bit i*5+o = input i requests output o; at most one bit set per input i.
- data_i  input  5*width_p  input flits; slice i = data_i[i*width_p +: width_p].
- yumi_o  output  5  bit i = input i's flit was dequeued this cycle.
- v_o  output  5  bit o = output register o holds a valid flit.
- data_o  output  5*width_p  output flits; slice o.
- ready_i  input  5  bit o = downstream link o accepts the flit this cycle.

## Operation
- Per-output state: v_r[o] (1 bit), data_r[o] (width_p), last_r[o] (3 bits, index of last granted input, range 0..4).
- Slot open: open[o] = ~v_r[o] | ready_i[o]. A full slot being drained the same cycle is open, so each output sustains one flit per cycle.
- Candidates for output o: cand[o][i] = req_i[i*5+o].
- Arbitration: when open[o], grant[o] is the first set cand[o][i] scanning i = last_r[o]+1, +2, … mod 5 (wrap 4→0). No candidate means no grant. When not open[o], no grant.
- yumi_o[i] = OR over o of grant[o][i]. This is legal because each input requests at most one output, so an input never wins two outputs.
- On clock edge, per output:
  - Grant to input g: data_r[o] <= data_i slice g; v_r[o] <= 1; last_r[o] <= g.
  - No grant and ready_i[o]: v_r[o] <= 0. data_r and last_r hold.
  - Otherwise all hold.
- Pointer advances only on a grant. A requester loses at most 4 consecutive grants on a continuously open output.
- ready_i[o] while v_r[o]=0 has no effect.
- v_o = v_r, data_o = data_r.
- Illegal input (more than one req bit for one input) produces an error message in simulation only. Hardware behaviour is unspecified.

## Timing
- Reset (reset_i=1 at an edge): v_r <= 0; data_r <= 0; last_r[o] <= 4, so input 0 has first priority. yumi_o is forced to 0 while reset_i is high.
- yumi_o is combinational from req_i, ready_i, v_r and last_r. There are no registers on this path.
- Latency: granted flit appears on v_o/data_o in the cycle after yumi_o.
- Flit transfer on output o occurs in any cycle with v_o[o] & ready_i[o]. A new flit may be loaded in that same cycle.
- data_r is stable while v_r=1 and ready_i=0; data_o is held until accepted.
- Reset mid-operation: buffered flits are dropped, no yumi is issued in reset cycles, and arbitration restarts from input 0 on the first cycle after reset.
- Simultaneous requests on different outputs are fully independent; up to 5 yumis fire per cycle.

## Test plan
- Reset then idle: after reset, v_o=0, data_o=0, yumi_o=0. Then req_i bit 0*5+2=1 with data_i[0]=0xA5A5A5A5 → yumi_o=5'b00001 the same cycle; next cycle v_o[2]=1, data_o[2]=0xA5A5A5A5.
- Round-robin fairness: inputs 1, 3, 4 continuously request output 0 (bits 5, 15, 20) with ready_i[0]=1 → grant order 1,3,4,1,3,4; one flit per cycle on v_o[0].
- Backpressure: output 1 full, ready_i[1]=0, input 2 requesting → yumi_o[2]=0 and data_o[1] stable for 10 cycles. Raise ready_i[1] → same cycle yumi_o[2]=1; next cycle data_o[1]=input 2's flit.
- Parallel outputs: inputs 0..4 request outputs 4,3,2,1,0 respectively, all ready → yumi_o=5'b11111; next cycle every v_o=1 with the crossed data.
- Drain without refill: v_o[3]=1, ready_i[3]=1, no requests → next cycle v_o[3]=0 and last_r[3] unchanged. The next contest between inputs 0 and 4 resolves by the previous pointer.
- Reset mid-stream: assert reset_i during fairness traffic → outputs clear next cycle and yumi_o=0 during reset. After release, input 1 wins first among {1,3,4}.

Source files
------------

// File: rtl/bsg_mesh_router_output_arb_5.sv
// Output stage of the 5-port DOR mesh router: per-output round-robin arbitration
// over the decoder's request matrix, feeding a one-entry valid/ready output register.
module bsg_mesh_router_output_arb_5 #(
    parameter int width_p = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [24:0]            req_i,
    input  logic [5*width_p-1:0]   data_i,
    output logic [4:0]             yumi_o,
    output logic [4:0]             v_o,
    output logic [5*width_p-1:0]   data_o,
    input  logic [4:0]             ready_i
);

    logic [4:0]                v_r;
    logic [4:0][width_p-1:0]   data_r;
    logic [4:0][2:0]           last_r;

    logic [4:0]                slot_open;
    logic [4:0]                gnt_any;
    logic [4:0][2:0]           gnt_sel;

    // Scan starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        int unsigned idx;
        slot_open = ~v_r | ready_i;
        gnt_any   = '0;
        gnt_sel   = '0;
        yumi_o    = '0;
        idx       = 0;
        for (int unsigned o = 0; o < 5; o++) begin
            for (int unsigned k = 1; k <= 5; k++) begin
                idx = (32'(last_r[o]) + k) % 5;
                if (slot_open[o] && !reset_i && !gnt_any[o] && req_i[idx*5 + o]) begin
                    gnt_any[o] = 1'b1;
                    gnt_sel[o] = 3'(idx);
                end
            end
            if (gnt_any[o]) begin
                yumi_o[gnt_sel[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_r    <= '0;
            data_r <= '0;
            for (int unsigned o = 0; o < 5; o++) begin
                last_r[o] <= 3'd4;
            end
        end else begin
            for (int unsigned o = 0; o < 5; o++) begin
                if (gnt_any[o]) begin
                    data_r[o] <= data_i[32'(gnt_sel[o])*width_p +: width_p];
                    v_r[o]    <= 1'b1;
                    last_r[o] <= gnt_sel[o];
                end else if (ready_i[o]) begin
                    v_r[o] <= 1'b0;
                end
            end
        end
    end

    assign v_o    = v_r;
    assign data_o = data_r;

    // Each input may target at most one output; otherwise two outputs could both dequeue it.
    for (genvar gi = 0; gi < 5; gi++) begin : g_req_chk
        assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(req_i[gi*5 +: 5]))
            else $error("input %0d requests more than one output", gi);
    end

endmodule
